seq_divider: RTL

- Parametrised restoring shift-subtract divider, one quotient bit per clock.
- Computes quotient = floor(dividend * 2^FRAC / divisor) and the matching remainder.
- Start/busy/done handshake; explicit divide-by-zero reporting.
- Serves as the general divider for fixed-point datapath blocks, replacing fixed-width 3-cycles-per-bit dividers.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 110 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing helper for the iteration counter.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // ceil(log2(n)) bits are enough to count 0..n-1; never return a zero-width counter
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next numerator bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic             num_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             qbit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;
    logic           fits;

    // A set MSB in partial_rem would already exceed any divisor, so it also forces a subtract
    always_comb begin
        t        = {partial_rem[WIDTH-1:0], num_bit};
        diff     = t - {1'b0, divisor};
        fits     = partial_rem[WIDTH] || (t >= {1'b0, divisor});
        qbit     = fits;
        next_rem = fits ? diff : t;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider producing floor(dividend * 2^FRAC / divisor),
// one quotient bit per clock, with start/busy/done handshake and divide-by-zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int FRAC  = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      dividend,
    input  logic [WIDTH-1:0]      divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [WIDTH+FRAC-1:0] quotient,
    output logic [WIDTH-1:0]      remainder
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = cnt_width(QW);

    div_state_t     state;
    div_state_t     state_next;
    logic [CW-1:0]  cnt;
    logic [QW-1:0]  numer;
    logic [QW-1:0]  work_q;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0] prem;
    logic [WIDTH:0] step_rem;
    logic           step_qbit;
    logic           accept;
    logic           last_iter;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CW'(QW - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (prem),
        .num_bit     (numer[QW-1]),
        .divisor     (dvsr),
        .next_rem    (step_rem),
        .qbit        (step_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A zero divisor skips CALC entirely and reports straight from DONE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_next = (divisor == '0) ? DONE : CALC;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are only written when an operation finishes, so they hold between runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            numer       <= '0;
            work_q      <= '0;
            dvsr        <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                numer       <= QW'(dividend) << FRAC;
                dvsr        <= divisor;
                prem        <= '0;
                work_q      <= '0;
                cnt         <= '0;
                div_by_zero <= 1'b0;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            numer  <= numer << 1;
            prem   <= step_rem;
            work_q <= {work_q[QW-2:0], step_qbit};
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
                quotient  <= {work_q[QW-2:0], step_qbit};
                remainder <= step_rem[WIDTH-1:0];
            end
        end
    end

endmodule
